// File: rtl/march_bist_ctrl_if.sv
// March C- BIST sequencer bus: control strobes to the address/data
// generators and memory, comparator feedback, and the result report.
interface march_bist_ctrl_if #(
   parameter int unsigned ADR_SIZE = 4
);
   logic                start;
   logic                c_out;
   logic                error;
   logic                wr_en;
   logic                read_en;
   logic                rst_adr;
   logic                pr_res_adr;
   logic                enable;
   logic                up_down;
   logic                data_bit;
   logic                busy;
   logic                done;
   logic                status;
   logic [ADR_SIZE-1:0] fail_adr;
   logic [2:0]          fail_elem;

   // Sequencer side.
   modport master (
      input  start, c_out, error,
      output wr_en, read_en, rst_adr, pr_res_adr, enable, up_down, data_bit,
             busy, done, status, fail_adr, fail_elem
   );

   // BIST datapath / host side.
   modport slave (
      output start, c_out, error,
      input  wr_en, read_en, rst_adr, pr_res_adr, enable, up_down, data_bit,
             busy, done, status, fail_adr, fail_elem
   );
endinterface

// File: rtl/march_bist_ctrl.sv
// March C- sequencer: walks elements E0..E5 over 2^ADR_SIZE words, one
// memory operation per cycle, and records the first miscompare.
module march_bist_ctrl #(
   parameter int unsigned ADR_SIZE     = 4,
   parameter bit          STOP_ON_FAIL = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   march_bist_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_RD,
      S_WR,
      S_DONE
   } state_t;

   localparam logic [ADR_SIZE-1:0] ADR_MAX = '1;

   state_t              state_q, state_d;
   logic [2:0]          elem_q, elem_d;
   logic [ADR_SIZE-1:0] adr_q, adr_d;
   logic                status_q, status_d;
   logic [ADR_SIZE-1:0] fail_adr_q, fail_adr_d;
   logic [2:0]          fail_elem_q, fail_elem_d;

   logic elem_up;
   logic rd_bit;
   logic wr_bit;
   logic adr_step_up;
   logic [ADR_SIZE-1:0] adr_next;

   logic wr_en, read_en, rst_adr, pr_res_adr, enable, up_down, data_bit;
   logic busy, done;

   // Per-element direction and background values: E3/E4 run downward,
   // E2/E4 read ones, E1/E3 write ones.
   always_comb begin
      elem_up     = !((elem_q == 3'd3) || (elem_q == 3'd4));
      rd_bit      = (elem_q == 3'd2) || (elem_q == 3'd4);
      wr_bit      = (elem_q == 3'd1) || (elem_q == 3'd3);
      adr_step_up = elem_up;
      adr_next    = adr_step_up ? (adr_q + 1'b1) : (adr_q - 1'b1);
   end

   // Next-state, shadow address, result capture and strobe decode.
   always_comb begin
      state_d     = state_q;
      elem_d      = elem_q;
      adr_d       = adr_q;
      status_d    = status_q;
      fail_adr_d  = fail_adr_q;
      fail_elem_d = fail_elem_q;
      wr_en       = 1'b0;
      read_en     = 1'b0;
      rst_adr     = 1'b0;
      pr_res_adr  = 1'b0;
      enable      = 1'b0;
      up_down     = 1'b0;
      data_bit    = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d     = S_SETUP;
               elem_d      = 3'd0;
               status_d    = 1'b1;
               fail_adr_d  = '0;
               fail_elem_d = '0;
            end
         end

         S_SETUP: begin
            busy       = 1'b1;
            up_down    = elem_up;
            rst_adr    = elem_up;
            pr_res_adr = !elem_up;
            adr_d      = elem_up ? '0 : ADR_MAX;
            state_d    = (elem_q == 3'd0) ? S_WR : S_RD;
         end

         S_RD: begin
            busy     = 1'b1;
            up_down  = elem_up;
            read_en  = 1'b1;
            data_bit = rd_bit;
            if (bus.error && status_q) begin
               status_d    = 1'b0;
               fail_adr_d  = adr_q;
               fail_elem_d = elem_q;
            end
            if (elem_q == 3'd5) begin
               enable = 1'b1;
            end
            // Abort takes priority over both element end and the RD->WR step.
            if (STOP_ON_FAIL && bus.error) begin
               state_d = S_DONE;
            end else if (elem_q == 3'd5) begin
               if (bus.c_out) begin
                  state_d = S_DONE;
               end else begin
                  adr_d = adr_next;
               end
            end else begin
               state_d = S_WR;
            end
         end

         S_WR: begin
            busy     = 1'b1;
            up_down  = elem_up;
            wr_en    = 1'b1;
            data_bit = wr_bit;
            enable   = 1'b1;
            if (bus.c_out) begin
               elem_d  = elem_q + 3'd1;
               state_d = S_SETUP;
            end else begin
               adr_d   = adr_next;
               state_d = (elem_q == 3'd0) ? S_WR : S_RD;
            end
         end

         S_DONE: begin
            done = 1'b1;
            if (bus.start) begin
               state_d     = S_SETUP;
               elem_d      = 3'd0;
               status_d    = 1'b1;
               fail_adr_d  = '0;
               fail_elem_d = '0;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         elem_q      <= 3'd0;
         adr_q       <= '0;
         status_q    <= 1'b1;
         fail_adr_q  <= '0;
         fail_elem_q <= '0;
      end else begin
         state_q     <= state_d;
         elem_q      <= elem_d;
         adr_q       <= adr_d;
         status_q    <= status_d;
         fail_adr_q  <= fail_adr_d;
         fail_elem_q <= fail_elem_d;
      end
   end

   assign bus.wr_en      = wr_en;
   assign bus.read_en    = read_en;
   assign bus.rst_adr    = rst_adr;
   assign bus.pr_res_adr = pr_res_adr;
   assign bus.enable     = enable;
   assign bus.up_down    = up_down;
   assign bus.data_bit   = data_bit;
   assign bus.busy       = busy;
   assign bus.done       = done;
   assign bus.status     = status_q;
   assign bus.fail_adr   = fail_adr_q;
   assign bus.fail_elem  = fail_elem_q;

endmodule
